apb_reg_completer: RTL and testbench

APB completer (slave) that terminates transfers issued by the processor's APB initiator path and exposes a small word-addressed register bank to the I2C-side logic. It decodes the setup/access phases, inserts a parameterised number of wait states, commits writes, returns read data, flags illegal accesses with PSLVERR, and emits per-register write strobes to downstream logic.

---
 rtl/apb_reg_completer_if.sv | 25 ++
 rtl/apb_reg_completer.sv | 121 ++++++++++++
 tb/tb_apb_reg_completer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_completer_if.sv
// APB bus bundle between the processor-side initiator and the register completer.
// Clock and reset travel as plain ports on the modules.
interface apb_reg_completer_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_reg_completer.sv
// APB completer exposing a word-addressed register bank (last entry read-only status)
// with programmable wait states, PSLVERR on illegal accesses and per-register write strobes.
module apb_reg_completer #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   apb_reg_completer_if.slave    apb,
   input  logic [DATA_WIDTH-1:0] status_in,
   output logic [DATA_WIDTH-1:0] ctrl_out,
   output logic [NUM_REGS-1:0]   wr_strobe
);

   localparam int unsigned IdxFullW = ADDR_WIDTH - 2;
   localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned CntW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [NUM_REGS-1:0]   strobe_q, strobe_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic [IdxFullW-1:0] setup_idx;
   logic                setup_err;
   logic                setup;
   logic                cnt_zero;
   logic                ready;
   logic                commit;

   assign setup_idx = apb.PADDR[ADDR_WIDTH-1:2];
   assign setup_err = (apb.PADDR[1:0] != 2'b00) ||
                      (32'(setup_idx) >= NUM_REGS) ||
                      (apb.PWRITE && (32'(setup_idx) == NUM_REGS - 1));
   assign setup     = (state_q == StIdle) && apb.PSEL && !apb.PENABLE;
   assign cnt_zero  = (cnt_q == '0);
   // PSEL is the only live input into PREADY: it lets an aborted access never report ready.
   assign ready     = (state_q == StAccess) && apb.PSEL && cnt_zero;
   assign commit    = ready && apb.PENABLE && write_q && !err_q;

   // State register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (setup) state_d = StAccess;
         StAccess: if (!apb.PSEL || cnt_zero) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      apb.PREADY  = ready;
      apb.PSLVERR = ready && err_q;
      apb.PRDATA  = '0;
      if (ready && !write_q && !err_q) begin
         apb.PRDATA = (32'(idx_q) == NUM_REGS - 1) ? status_in : regs_q[idx_q];
      end
   end

   // Datapath next-state: transfer context, wait counter, register bank, strobes
   always_comb begin
      cnt_d    = cnt_q;
      write_d  = write_q;
      err_d    = err_q;
      idx_d    = idx_q;
      regs_d   = regs_q;
      strobe_d = '0;
      if (setup) begin
         cnt_d   = CntW'(WAIT_CYCLES);
         write_d = apb.PWRITE;
         err_d   = setup_err;
         idx_d   = setup_idx[IdxW-1:0];
      end else if ((state_q == StAccess) && apb.PSEL && !cnt_zero) begin
         cnt_d = cnt_q - CntW'(1);
      end
      if (commit) begin
         regs_d[idx_q]   = apb.PWDATA;
         strobe_d[idx_q] = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         strobe_q <= '0;
         regs_q   <= '{default: '0};
      end else begin
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         strobe_q <= strobe_d;
         regs_q   <= regs_d;
      end
   end

   assign ctrl_out  = regs_q[0];
   assign wr_strobe = strobe_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: one instance with one wait state, one zero-wait,
// sharing the bus stimulus but selected by separate PSEL lines.
module tb_apb_reg_completer;

   logic        clk = 1'b0;
   logic        rst1_n, rst0_n;
   logic        psel1, psel0, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata, status_in;
   logic [31:0] ctrl1, ctrl0;
   logic [7:0]  strb1, strb0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   apb_reg_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();
   apb_reg_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();

   assign bus1.PSEL    = psel1;
   assign bus1.PENABLE = penable;
   assign bus1.PWRITE  = pwrite;
   assign bus1.PADDR   = paddr;
   assign bus1.PWDATA  = pwdata;
   assign bus0.PSEL    = psel0;
   assign bus0.PENABLE = penable;
   assign bus0.PWRITE  = pwrite;
   assign bus0.PADDR   = paddr;
   assign bus0.PWDATA  = pwdata;

   apb_reg_completer #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(1)
   ) u_dut1 (
      .PCLK(clk), .PRESETn(rst1_n), .apb(bus1.slave),
      .status_in(status_in), .ctrl_out(ctrl1), .wr_strobe(strb1)
   );

   apb_reg_completer #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(0)
   ) u_dut0 (
      .PCLK(clk), .PRESETn(rst0_n), .apb(bus0.slave),
      .status_in(status_in), .ctrl_out(ctrl0), .wr_strobe(strb0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the completion edge so a following
   // call starts its setup phase with no idle cycle in between.
   task automatic xfer(input bit use0, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int cyc);
      bit done;
      done    = 1'b0;
      rdata   = '0;
      err     = 1'b0;
      cyc     = 0;
      psel1   = !use0;
      psel0   = use0;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!done && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if ((use0 ? bus0.PREADY : bus1.PREADY) === 1'b1) begin
            done  = 1'b1;
            rdata = use0 ? bus0.PRDATA : bus1.PRDATA;
            err   = use0 ? bus0.PSLVERR : bus1.PSLVERR;
         end
         @(posedge clk); #1;
      end
      psel1   = 1'b0;
      psel0   = 1'b0;
      penable = 1'b0;
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: addr 0x%02h got no PREADY, expected within 8 cycles", addr);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          cy;

      rst1_n = 1'b0; rst0_n = 1'b0;
      psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; status_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pready",  bus1.PREADY,  32'd0);
      check("rst_pslverr", bus1.PSLVERR, 32'd0);
      check("rst_prdata",  bus1.PRDATA,  32'd0);
      check("rst_ctrl",    ctrl1,        32'd0);
      check("rst_strobe",  strb1,        32'd0);
      @(negedge clk);
      rst1_n = 1'b1; rst0_n = 1'b1;
      @(posedge clk); #1;

      // Write/read reg 1 with one wait state
      xfer(0, 1, 8'h04, 32'hDEADBEEF, rd, er, cy);
      check("w04_cycles", cy, 32'd2);
      check("w04_err",    er, 32'd0);
      check("w04_strobe", strb1, 32'h02);
      @(posedge clk); #1;
      check("w04_strobe_clr", strb1, 32'h00);
      xfer(0, 0, 8'h04, 32'h0, rd, er, cy);
      check("r04_data",   rd, 32'hDEADBEEF);
      check("r04_cycles", cy, 32'd2);
      check("r04_err",    er, 32'd0);

      // Reg 0 drives ctrl_out
      xfer(0, 1, 8'h00, 32'h000000A5, rd, er, cy);
      check("w00_ctrl",   ctrl1, 32'h000000A5);
      check("w00_strobe", strb1, 32'h01);

      // Status register: read-only, sampled at completion
      status_in = 32'h12345678;
      xfer(0, 0, 8'h1C, 32'h0, rd, er, cy);
      check("r1C_data", rd, 32'h12345678);
      check("r1C_err",  er, 32'd0);
      xfer(0, 1, 8'h1C, 32'hFFFFFFFF, rd, er, cy);
      check("w1C_err",    er, 32'd1);
      check("w1C_strobe", strb1, 32'h00);
      status_in = 32'hCAFEF00D;
      xfer(0, 0, 8'h1C, 32'h0, rd, er, cy);
      check("r1C_data2", rd, 32'hCAFEF00D);

      // Out-of-range and misaligned accesses
      xfer(0, 0, 8'h20, 32'h0, rd, er, cy);
      check("r20_err",  er, 32'd1);
      check("r20_data", rd, 32'd0);
      xfer(0, 1, 8'h20, 32'hFFFFFFFF, rd, er, cy);
      check("w20_err",    er, 32'd1);
      check("w20_strobe", strb1, 32'h00);
      xfer(0, 0, 8'h06, 32'h0, rd, er, cy);
      check("r06_err",  er, 32'd1);
      check("r06_data", rd, 32'd0);
      xfer(0, 1, 8'h06, 32'h55555555, rd, er, cy);
      check("w06_err",    er, 32'd1);
      check("w06_strobe", strb1, 32'h00);
      check("bad_ctrl",   ctrl1, 32'h000000A5);
      xfer(0, 0, 8'h04, 32'h0, rd, er, cy);
      check("bad_r04", rd, 32'hDEADBEEF);

      // PSEL dropped in the final access cycle
      psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h5A5A5A5A;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel1 = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("abort_pready", bus1.PREADY, 32'd0);
      check("abort_prdata", bus1.PRDATA, 32'd0);
      @(posedge clk); #1;
      check("abort_strobe", strb1, 32'h00);
      xfer(0, 0, 8'h0C, 32'h0, rd, er, cy);
      check("abort_r0C",    rd, 32'd0);
      check("abort_cycles", cy, 32'd2);

      // Reset pulsed during the wait cycle
      psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h77777777;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      rst1_n = 1'b0;
      #1;
      check("rstmid_pready", bus1.PREADY, 32'd0);
      @(posedge clk); #1;
      psel1 = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst1_n = 1'b1;
      @(posedge clk); #1;
      check("rstmid_strobe", strb1, 32'h00);
      check("rstmid_ctrl",   ctrl1, 32'd0);
      xfer(0, 0, 8'h0C, 32'h0, rd, er, cy);
      check("rstmid_r0C",    rd, 32'd0);
      check("rstmid_cycles", cy, 32'd2);
      xfer(0, 1, 8'h0C, 32'h00C0FFEE, rd, er, cy);
      check("post_w0C_err", er, 32'd0);
      xfer(0, 0, 8'h0C, 32'h0, rd, er, cy);
      check("post_r0C", rd, 32'h00C0FFEE);

      // Zero-wait instance: back-to-back write then read of reg 2
      xfer(1, 1, 8'h08, 32'h13572468, rd, er, cy);
      check("z_w08_cycles", cy, 32'd1);
      check("z_w08_err",    er, 32'd0);
      check("z_w08_strobe", strb0, 32'h04);
      xfer(1, 0, 8'h08, 32'h0, rd, er, cy);
      check("z_r08_cycles", cy, 32'd1);
      check("z_r08_data",   rd, 32'h13572468);
      check("z_ctrl",       ctrl0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

endmodule
